// File: rtl/rvfi_insn_capture.sv
// Counts retirements on a multi-channel RVFI stream in program order, latches the packet
// of the selected retired instruction into one channel and pulses check one cycle later.
module rvfi_insn_capture #(
    parameter int NRET = 2,
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int CNTW = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   arm,
    input  logic [CNTW-1:0]        trig_count,
    input  logic [NRET-1:0]        rvfi_valid,
    input  logic [NRET-1:0]        rvfi_trap,
    input  logic [NRET-1:0]        rvfi_halt,
    input  logic [NRET-1:0]        rvfi_intr,
    input  logic [NRET*ILEN-1:0]   rvfi_insn,
    input  logic [NRET*5-1:0]      rvfi_rs1_addr,
    input  logic [NRET*5-1:0]      rvfi_rs2_addr,
    input  logic [NRET*5-1:0]      rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0]   rvfi_rs1_rdata,
    input  logic [NRET*XLEN-1:0]   rvfi_rs2_rdata,
    input  logic [NRET*XLEN-1:0]   rvfi_rd_wdata,
    input  logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
    input  logic [NRET*XLEN-1:0]   rvfi_pc_wdata,
    input  logic [NRET*XLEN-1:0]   rvfi_mem_addr,
    input  logic [NRET*XLEN/8-1:0] rvfi_mem_rmask,
    input  logic [NRET*XLEN/8-1:0] rvfi_mem_wmask,
    input  logic [NRET*XLEN-1:0]   rvfi_mem_rdata,
    input  logic [NRET*XLEN-1:0]   rvfi_mem_wdata,
    output logic                   cap_trap,
    output logic                   cap_halt,
    output logic                   cap_intr,
    output logic [ILEN-1:0]        cap_insn,
    output logic [4:0]             cap_rs1_addr,
    output logic [4:0]             cap_rs2_addr,
    output logic [4:0]             cap_rd_addr,
    output logic [XLEN-1:0]        cap_rs1_rdata,
    output logic [XLEN-1:0]        cap_rs2_rdata,
    output logic [XLEN-1:0]        cap_rd_wdata,
    output logic [XLEN-1:0]        cap_pc_rdata,
    output logic [XLEN-1:0]        cap_pc_wdata,
    output logic [XLEN-1:0]        cap_mem_addr,
    output logic [XLEN/8-1:0]      cap_mem_rmask,
    output logic [XLEN/8-1:0]      cap_mem_wmask,
    output logic [XLEN-1:0]        cap_mem_rdata,
    output logic [XLEN-1:0]        cap_mem_wdata,
    output logic                   cap_valid,
    output logic                   check,
    output logic                   done,
    output logic                   missed,
    output logic [CNTW-1:0]        retired
);
    localparam int MW = XLEN / 8;
    localparam int PW = 3 + ILEN + 15 + 8 * XLEN + 2 * MW;
    localparam int KW = $clog2(NRET + 1);
    // Order indices are formed one carry wider than the counter plus popcount so they never wrap.
    localparam int IW = CNTW + KW + 1;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_CHECK, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] trig_q, trig_d;
    logic [CNTW-1:0] retired_q, retired_d;
    logic [PW-1:0]   cap_q, cap_d;
    logic            cap_valid_q, cap_valid_d;
    logic            missed_q, missed_d;
    logic            check_q, check_d;
    logic            done_q, done_d;

    logic [IW-1:0]   rank;
    logic [IW-1:0]   idx;
    logic            hit;
    logic            miss_halt;
    logic [PW-1:0]   hit_pkt;

    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a, input logic [IW-1:0] b);
        logic [IW-1:0] s;
        s = {{(IW-CNTW){1'b0}}, a} + b;
        if (s > {{(IW-CNTW){1'b0}}, {CNTW{1'b1}}})
            return {CNTW{1'b1}};
        return s[CNTW-1:0];
    endfunction

    // Rank valid channels (lower index is older) and look for the trigger or an earlier halt.
    always_comb begin
        rank      = '0;
        idx       = '0;
        hit       = 1'b0;
        miss_halt = 1'b0;
        hit_pkt   = '0;
        for (int c = 0; c < NRET; c++) begin
            if (rvfi_valid[c]) begin
                idx = {{(IW-CNTW){1'b0}}, retired_q} + rank;
                if (idx == {{(IW-CNTW){1'b0}}, trig_q} && !hit) begin
                    hit     = 1'b1;
                    hit_pkt = {rvfi_trap[c], rvfi_halt[c], rvfi_intr[c],
                               rvfi_insn[c*ILEN +: ILEN],
                               rvfi_rs1_addr[c*5 +: 5], rvfi_rs2_addr[c*5 +: 5], rvfi_rd_addr[c*5 +: 5],
                               rvfi_rs1_rdata[c*XLEN +: XLEN], rvfi_rs2_rdata[c*XLEN +: XLEN],
                               rvfi_rd_wdata[c*XLEN +: XLEN], rvfi_pc_rdata[c*XLEN +: XLEN],
                               rvfi_pc_wdata[c*XLEN +: XLEN], rvfi_mem_addr[c*XLEN +: XLEN],
                               rvfi_mem_rmask[c*MW +: MW], rvfi_mem_wmask[c*MW +: MW],
                               rvfi_mem_rdata[c*XLEN +: XLEN], rvfi_mem_wdata[c*XLEN +: XLEN]};
                end
                if (idx < {{(IW-CNTW){1'b0}}, trig_q} && rvfi_halt[c])
                    miss_halt = 1'b1;
                rank = rank + IW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arm) state_d = S_COUNT;
            S_COUNT: begin
                if (hit)
                    state_d = S_CHECK;
                else if (miss_halt)
                    state_d = S_DONE;
            end
            S_CHECK: state_d = S_DONE;
            S_DONE:  if (arm) state_d = S_COUNT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        trig_d      = trig_q;
        retired_d   = retired_q;
        cap_d       = cap_q;
        cap_valid_d = cap_valid_q;
        missed_d    = missed_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    trig_d      = trig_count;
                    retired_d   = '0;
                    cap_d       = '0;
                    cap_valid_d = 1'b0;
                    missed_d    = 1'b0;
                end
            end
            S_COUNT: begin
                retired_d = sat_add(retired_q, rank);
                if (hit) begin
                    cap_d       = hit_pkt;
                    cap_valid_d = 1'b1;
                end else if (miss_halt) begin
                    missed_d = 1'b1;
                end
            end
            default: ;
        endcase
        check_d = (state_d == S_CHECK);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            trig_q      <= '0;
            retired_q   <= '0;
            cap_q       <= '0;
            cap_valid_q <= 1'b0;
            missed_q    <= 1'b0;
            check_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            trig_q      <= trig_d;
            retired_q   <= retired_d;
            cap_q       <= cap_d;
            cap_valid_q <= cap_valid_d;
            missed_q    <= missed_d;
            check_q     <= check_d;
            done_q      <= done_d;
        end
    end

    assign {cap_trap, cap_halt, cap_intr, cap_insn, cap_rs1_addr, cap_rs2_addr, cap_rd_addr,
            cap_rs1_rdata, cap_rs2_rdata, cap_rd_wdata, cap_pc_rdata, cap_pc_wdata,
            cap_mem_addr, cap_mem_rmask, cap_mem_wmask, cap_mem_rdata, cap_mem_wdata} = cap_q;
    assign cap_valid = cap_valid_q;
    assign check     = check_q;
    assign done      = done_q;
    assign missed    = missed_q;
    assign retired   = retired_q;
endmodule
